// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, press/release strobes, run toggle.
// Latency: strobes/level change DEBOUNCE_CYCLES+2 edges after the first raw sample of a new level.
// No backpressure; optional long-press one-shot when BTN_LONG_PRESS_EN is defined.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int LONG_CYCLES     = 100_000_000,
   parameter int CNT_W           = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long,
   output logic run
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Terminal count of the debounce window, shared by press and release.
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Illegal parameter sets are rejected at elaboration time.
   if ((DEBOUNCE_CYCLES < 2) || (LONG_CYCLES <= DEBOUNCE_CYCLES) ||
       (((LONG_CYCLES - 1) >> CNT_W) != 0)) begin : g_bad_cfg
      $error("button_conditioner: illegal DEBOUNCE_CYCLES/LONG_CYCLES/CNT_W");
   end

   logic             meta_q, meta_d;
   logic             sync_q, sync_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             run_q, run_d;

`ifdef BTN_LONG_PRESS_EN
   // Hold time reaching this value marks a long press; hcnt saturates here.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic             long_done_q, long_done_d;
   logic             long_q, long_d;
`endif

   // Next-state logic: synchroniser shift, debounce FSM, strobes and run enable.
   always_comb begin
      meta_d    = button;
      sync_d    = meta_q;
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      run_d     = run_q;
`ifdef BTN_LONG_PRESS_EN
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      long_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (sync_q) begin
               state_d = PRESS_WAIT;
               dcnt_d  = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_q) begin
               // Too short to be a press: drop it silently.
               state_d = IDLE;
            end else if (dcnt_q == DEB_LAST) begin
               state_d = PRESSED;
               level_d = 1'b1;
               press_d = 1'b1;
               run_d   = ~run_q;
`ifdef BTN_LONG_PRESS_EN
               hcnt_d      = '0;
               long_done_d = 1'b0;
`endif
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync_q) begin
               state_d = RELEASE_WAIT;
               dcnt_d  = '0;
            end else begin
`ifdef BTN_LONG_PRESS_EN
               if (hcnt_q != LONG_LAST) begin
                  hcnt_d = hcnt_q + 1'b1;
               end else if (!long_done_q) begin
                  // One long strobe per debounced press; it stops the pattern.
                  long_d      = 1'b1;
                  long_done_d = 1'b1;
                  run_d       = 1'b0;
               end
`endif
            end
         end
         RELEASE_WAIT: begin
            if (sync_q) begin
               // Release bounced back: still the same press, so long_done stays.
               state_d = PRESSED;
`ifdef BTN_LONG_PRESS_EN
               hcnt_d = '0;
`endif
            end else if (dcnt_q == DEB_LAST) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q    <= 1'b0;
         sync_q    <= 1'b0;
         state_q   <= IDLE;
         dcnt_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         meta_q    <= meta_d;
         sync_q    <= sync_d;
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         run_q     <= run_d;
      end
   end

`ifdef BTN_LONG_PRESS_EN
   // Long-press hold counter and one-shot bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt_q      <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         hcnt_q      <= hcnt_d;
         long_done_q <= long_done_d;
         long_q      <= long_d;
      end
   end

   assign btn_long = long_q;
`else
   assign btn_long = 1'b0;
`endif

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign run         = run_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Long-press expectations follow whether BTN_LONG_PRESS_EN is defined.
module tb_button_conditioner;

   logic clk;
   logic rst;
   logic button;
   logic btn_level;
   logic btn_press;
   logic btn_release;
   logic btn_long;
   logic run;

   int checks   = 0;
   int failures = 0;

   int n_press   = 0;
   int n_release = 0;
   int n_long    = 0;

   int s_press;
   int s_release;
   int s_long;

`ifdef BTN_LONG_PRESS_EN
   localparam logic LONG_EN = 1'b1;
`else
   localparam logic LONG_EN = 1'b0;
`endif

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES    (20),
      .CNT_W          (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .button     (button),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_long   (btn_long),
      .run        (run)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (btn_press === 1'b1)   n_press++;
      if (btn_release === 1'b1) n_release++;
      if (btn_long === 1'b1)    n_long++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_press   = n_press;
      s_release = n_release;
      s_long    = n_long;
   endtask

   initial begin
      // Reset held with the button already pressed.
      rst    = 1'b0;
      button = 1'b1;
      tick(3);
      chk("rst_level",   32'(btn_level),   0);
      chk("rst_press",   32'(btn_press),   0);
      chk("rst_release", 32'(btn_release), 0);
      chk("rst_long",    32'(btn_long),    0);
      chk("rst_run",     32'(run),         0);

      // Release reset; first high sample at edge N, press after N+6.
      rst = 1'b1;
      tick(6);
      chk("first_press_early", 32'(btn_press), 0);
      chk("first_level_early", 32'(btn_level), 0);
      tick(1);
      chk("first_press", 32'(btn_press), 1);
      chk("first_level", 32'(btn_level), 1);
      chk("first_run",   32'(run),       1);
      tick(1);
      chk("first_press_width", 32'(btn_press), 0);

      // Let go: release strobe after edge M+6.
      button = 1'b0;
      tick(6);
      chk("first_release_early", 32'(btn_release), 0);
      chk("first_level_held",    32'(btn_level),   1);
      tick(1);
      chk("first_release", 32'(btn_release), 1);
      chk("first_rel_lvl", 32'(btn_level),   0);
      tick(1);
      chk("first_release_width", 32'(btn_release), 0);

      // Clean press held 10 cycles: second press toggles run back to 0.
      snap();
      button = 1'b1;
      tick(6);
      chk("clean_press_early", 32'(btn_press), 0);
      tick(1);
      chk("clean_press", 32'(btn_press), 1);
      chk("clean_run",   32'(run),       0);
      tick(3);
      chk("clean_press_once", 32'(n_press - s_press), 1);
      chk("clean_level_held", 32'(btn_level),         1);
      button = 1'b0;
      tick(7);
      chk("clean_release", 32'(btn_release), 1);
      chk("clean_rel_lvl", 32'(btn_level),   0);
      tick(1);
      chk("clean_release_once", 32'(n_release - s_release), 1);

      // Glitch: 3-cycle pulse from IDLE is rejected.
      snap();
      button = 1'b1;
      tick(3);
      button = 1'b0;
      tick(10);
      chk("glitch_level",   32'(btn_level),             0);
      chk("glitch_press",   32'(n_press - s_press),     0);
      chk("glitch_release", 32'(n_release - s_release), 0);
      chk("glitch_run",     32'(run),                   0);

      // Bounce every 2 cycles, then hold: exactly one press.
      snap();
      for (int i = 0; i < 5; i++) begin
         button = 1'b1;
         tick(2);
         button = 1'b0;
         tick(2);
      end
      chk("bounce_no_press", 32'(n_press - s_press), 0);
      button = 1'b1;
      tick(10);
      chk("bounce_press",   32'(n_press - s_press),     1);
      chk("bounce_release", 32'(n_release - s_release), 0);
      chk("bounce_level",   32'(btn_level),             1);
      chk("bounce_run",     32'(run),                   1);

      // Keep holding (40 cycles from first high sample N); long at N+26.
      tick(16);
      chk("long_early", 32'(n_long - s_long), 0);
      tick(1);
      chk("long_strobe", 32'(btn_long), 32'(LONG_EN));
      chk("long_run",    32'(run),      32'(!LONG_EN));
      tick(1);
      chk("long_width", 32'(btn_long), 0);
      tick(13);
      chk("long_count",     32'(n_long - s_long),   32'(LONG_EN));
      chk("hold_no_repeat", 32'(n_press - s_press), 1);
      button = 1'b0;
      tick(7);
      chk("long_release",     32'(btn_release), 1);
      chk("long_release_lvl", 32'(btn_level),   0);
      tick(1);
      chk("long_release_once", 32'(n_release - s_release), 1);

      // Reset in the middle of a debounce discards the press.
      snap();
      button = 1'b1;
      tick(4);
      rst = 1'b0;
      #2;
      chk("midrst_run",   32'(run),       0);
      chk("midrst_level", 32'(btn_level), 0);
      rst = 1'b1;
      tick(6);
      chk("midrst_no_press", 32'(n_press - s_press), 0);
      tick(1);
      chk("midrst_press", 32'(btn_press), 1);
      chk("midrst_run2",  32'(run),       1);
      tick(2);
      chk("total_long", 32'(n_long), 32'(LONG_EN));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
